dev_timer: RTL and testbench

//  Programmable countdown timer, device 0 behind the CPU/peripheral bridge (window 0x0000_7F00-0x0000_7F0F).

---
 rtl/dev_timer_pkg.sv | 38 +++
 rtl/dev_timer.sv | 116 +++++++++++
 tb/tb_dev_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dev_timer_pkg.sv
// Shared definitions for the bridge-attached countdown timer: register map,
// CTRL field layout, mode encodings and FSM states.
package dev_timer_pkg;

    localparam logic [31:0] DevBase = 32'h0000_7F00;

    // Word offsets decoded from Addr[3:2]
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPreset = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegRsvd   = 2'd3;

    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlImBit   = 3;

    localparam logic [1:0] ModeOneShot    = 2'd0;
    localparam logic [1:0] ModeAutoReload = 2'd1;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    // Modes 2 and 3 fall back to one-shot behaviour
    function automatic logic is_auto_reload(input logic [1:0] mode);
        return mode == ModeAutoReload;
    endfunction

endpackage

// File: rtl/dev_timer.sv
// Programmable countdown timer: CTRL/PRESET/COUNT register file, control FSM
// and decrementer, with an interrupt request gated by CTRL.IM.
module dev_timer
    import dev_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    state_e           state_q, state_d;

    logic unused_bits;
    assign unused_bits = ^{Addr[31:4], WD};

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        state_d  = state_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_q.en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
                // Auto-reload interrupt is a single-cycle pulse
                if (is_auto_reload(ctrl_q.mode)) begin
                    flag_d = 1'b0;
                end
            end
            StCnt: begin
                if (!ctrl_q.en) begin
                    state_d = StIdle;
                end else if (count_q == '0) begin
                    state_d = StInt;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            StInt: begin
                flag_d = 1'b1;
                if (is_auto_reload(ctrl_q.mode)) begin
                    state_d = StLoad;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // CPU writes override FSM updates of the same cycle
        if (WE) begin
            case (Addr[3:2])
                RegCtrl: begin
                    ctrl_d.en   = WD[CtrlEnBit];
                    ctrl_d.mode = WD[CtrlModeLsb +: 2];
                    ctrl_d.im   = WD[CtrlImBit];
                    flag_d      = 1'b0;
                end
                RegPreset: begin
                    preset_d = WD[CNT_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            state_q  <= StIdle;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        RD = '0;
        case (Addr[3:2])
            RegCtrl:   RD = 32'(ctrl_q);
            RegPreset: RD = 32'(preset_q);
            RegCount:  RD = 32'(count_q);
            default:   RD = '0;
        endcase
    end

    assign IRQ = ctrl_q.im & flag_q;

endmodule

// File: tb/tb_dev_timer.sv
// Directed bench for dev_timer: register access, one-shot, auto-reload,
// zero preset, mid-count disable, reset and write-collision cases.
module tb_dev_timer;

    logic        clk;
    logic        reset;
    logic [31:2] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] base = dev_timer_pkg::DevBase;

    dev_timer #(.CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (addr),
        .WE    (we),
        .WD    (wd),
        .RD    (rd),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        addr = {base[31:4], off};
        wd   = data;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        addr = {base[31:4], off};
        #1;
        check(tag, rd, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, 32'(irq), 32'(exp));
    endtask

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        wd    = '0;
        addr  = {base[31:4], 2'd0};
        #12;
        chk_reg("rst_ctrl", 2'd0, 32'h0);
        chk_reg("rst_preset", 2'd1, 32'h0);
        chk_reg("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b1;
        tick(1);

        // Reset mid-count
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        tick(5);
        chk_reg("t1_count5", 2'd2, 32'd5);
        #1 reset = 1'b0;
        #1;
        chk_irq("t1_irq_rst", 1'b0);
        chk_reg("t1_ctrl_rst", 2'd0, 32'h0);
        chk_reg("t1_preset_rst", 2'd1, 32'h0);
        chk_reg("t1_count_rst", 2'd2, 32'h0);
        tick(1);
        reset = 1'b1;
        tick(6);
        chk_reg("t1_count_idle", 2'd2, 32'h0);
        chk_reg("t1_ctrl_idle", 2'd0, 32'h0);
        chk_irq("t1_irq_idle", 1'b0);

        // One-shot, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(2);
        chk_reg("t2_count3", 2'd2, 32'd3);
        tick(1);
        chk_reg("t2_count2", 2'd2, 32'd2);
        tick(1);
        chk_reg("t2_count1", 2'd2, 32'd1);
        tick(1);
        chk_reg("t2_count0", 2'd2, 32'd0);
        tick(1);
        chk_irq("t2_irq_t6", 1'b0);
        tick(1);
        chk_irq("t2_irq_t7", 1'b1);
        chk_reg("t2_ctrl_en_clr", 2'd0, 32'h8);
        tick(3);
        chk_irq("t2_irq_held", 1'b1);
        chk_reg("t2_count_hold", 2'd2, 32'd0);
        wr(2'd0, 32'h0);
        chk_irq("t2_irq_clr", 1'b0);
        tick(2);

        // Auto-reload, PRESET=2: period 5
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        tick(5);
        chk_irq("t3_irq_t5", 1'b0);
        for (int p = 0; p < 3; p++) begin
            tick(1);
            chk_irq($sformatf("t3_pulse%0d", p), 1'b1);
            tick(1);
            chk_irq($sformatf("t3_after%0d", p), 1'b0);
            chk_reg($sformatf("t3_reload%0d", p), 2'd2, 32'd2);
            tick(3);
            chk_irq($sformatf("t3_gap%0d", p), 1'b0);
        end
        wr(2'd0, 32'h0);
        tick(4);

        // PRESET=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_reg("t4_count_t2", 2'd2, 32'd0);
        chk_irq("t4_irq_t2", 1'b0);
        tick(1);
        chk_irq("t4_irq_t3", 1'b0);
        tick(1);
        chk_irq("t4_irq_t4", 1'b1);
        tick(3);
        chk_reg("t4_no_wrap", 2'd2, 32'd0);
        wr(2'd0, 32'h0);
        tick(3);

        // Disable mid-count then re-enable
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        chk_reg("t5_count7", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        chk_reg("t5_count6", 2'd2, 32'd6);
        tick(3);
        chk_reg("t5_frozen", 2'd2, 32'd6);
        chk_irq("t5_irq", 1'b0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_reg("t5_reload", 2'd2, 32'd10);
        wr(2'd0, 32'h0);
        tick(4);
        chk_reg("t5_stop", 2'd2, 32'd9);

        // Read-only/reserved writes and CTRL write colliding with INT
        wr(2'd2, 32'h55);
        chk_reg("t6_count_ro", 2'd2, 32'd9);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_reg("t6_rsvd", 2'd3, 32'h0);
        chk_reg("t6_preset_kept", 2'd1, 32'd10);
        chk_reg("t6_ctrl_kept", 2'd0, 32'h0);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick(4);
        chk_irq("t6_irq_pre", 1'b0);
        wr(2'd0, 32'hD);
        chk_reg("t6_ctrl_win", 2'd0, 32'hD);
        chk_irq("t6_irq_clr", 1'b0);
        wr(2'd0, 32'h0);
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
